// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate plus register/funct fields into a RISC-V I/S/B/J/U word.
// Define LI_EXPAND_EN to enable LI pseudo-op expansion into LUI+ADDI (adds the SECOND state).
module imm_encoder #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013,
   parameter bit          STRICT    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_imm,
   input  logic        in_li,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err,
   output logic        out_last
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic {IDLE, SECOND} state_t;

   state_t      state;
   state_t      state_next;
   logic        accept;
   logic        consume;
   logic [31:0] enc_instr;
   logic        enc_err;
   logic        enc_last;
   logic        enc_second;
   logic [31:0] enc_pending;
   logic [31:0] pending;
   logic        fits12;
   logic        fits13;
   logic        fits21;

   // A value fits an N-bit signed field when all bits above the field's sign bit match it.
   assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
   assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

   assign in_ready = (state == IDLE) & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign consume  = out_valid & out_ready;

`ifdef LI_EXPAND_EN
   logic [19:0] li_hi;
   logic        li_lo_nz;
   assign li_hi    = in_imm[31:12] + {19'd0, in_imm[11]};
   assign li_lo_nz = |in_imm[11:0];
`else
   logic unused_li;
   assign unused_li = in_li;
`endif

   always_comb begin
      enc_instr   = NOP_INSTR;
      enc_err     = 1'b1;
      enc_last    = 1'b1;
      enc_second  = 1'b0;
      enc_pending = '0;
      case (in_opcode)
         OP_LOAD, OP_IMM: begin
            enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            enc_err   = STRICT && !fits12;
         end
         OP_STORE: begin
            enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            enc_err   = STRICT && !fits12;
         end
         OP_BRANCH: begin
            enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
            enc_err   = STRICT && (!fits13 || in_imm[0]);
         end
         OP_JAL: begin
            enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            enc_err   = STRICT && (!fits21 || in_imm[0]);
         end
         OP_LUI: begin
            enc_instr = {in_imm[31:12], in_rd, in_opcode};
            enc_err   = STRICT && (|in_imm[11:0]);
         end
         default: ;
      endcase
`ifdef LI_EXPAND_EN
      // The LUI upper part is rounded up when the low 12 bits will sign-extend negative.
      if (in_li) begin
         enc_err = 1'b0;
         if (fits12) begin
            enc_instr = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM};
         end else begin
            enc_instr   = {li_hi, in_rd, OP_LUI};
            enc_last    = ~li_lo_nz;
            enc_second  = li_lo_nz;
            enc_pending = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM};
         end
      end
`endif
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && enc_second) state_next = SECOND;
         SECOND:  if (consume) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Output slot: loads on accept, swaps in the pending ADDI in SECOND, empties otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_err   <= 1'b0;
         out_last  <= 1'b0;
         pending   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_instr <= enc_instr;
         out_err   <= enc_err;
         out_last  <= enc_last;
         pending   <= enc_pending;
      end else if (consume) begin
         if (state == SECOND) begin
            out_instr <= pending;
            out_err   <= 1'b0;
            out_last  <= 1'b1;
            pending   <= '0;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized checks of imm_encoder against a value-level model.
// Honours LI_EXPAND_EN the same way as the design.
module tb_imm_encoder;

   localparam bit          STRICT    = 1'b1;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_imm = '0;
   logic        in_li = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic        out_err;
   logic        out_last;

   int total = 0;
   int bad = 0;

   logic [31:0] exp_instr_q[$];
   logic        exp_err_q[$];
   logic        exp_last_q[$];

   always #5 clk = ~clk;

   imm_encoder #(.NOP_INSTR(NOP_INSTR), .STRICT(STRICT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_imm(in_imm), .in_li(in_li),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
   );

   function automatic void pushExp(longint w, bit e, bit l);
      logic [63:0] wv;
      wv = 64'(w);
      exp_instr_q.push_back(wv[31:0]);
      exp_err_q.push_back(e);
      exp_last_q.push_back(l);
   endfunction

   function automatic longint addiWord(longint rd, longint rs, longint val);
      return ((val & 'hFFF) << 20) + (rs << 15) + (rd << 7) + 'h13;
   endfunction

   // Reference model: value-range rules on the signed immediate, words built by arithmetic.
   function automatic void modelRequest(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                        logic [4:0] rs2, logic [2:0] f3, logic [31:0] imm,
                                        logic li);
      longint v, u, w, lo, hi, o, d, s1, s2, f;
      bit ok, li_on;
      v = longint'($signed(imm));
      u = longint'(imm);
      o = longint'(op); d = longint'(rd); s1 = longint'(rs1); s2 = longint'(rs2); f = longint'(f3);
`ifdef LI_EXPAND_EN
      li_on = li;
`else
      li_on = 1'b0 & li;
`endif
      if (li_on) begin
         if (v >= -2048 && v <= 2047) begin
            pushExp(addiWord(d, 0, v), 1'b0, 1'b1);
         end else begin
            lo = ((v & 'hFFF) ^ 'h800) - 'h800;
            hi = ((v - lo) >>> 12) & 'hFFFFF;
            w  = (hi << 12) + (d << 7) + 'h37;
            if (lo == 0) pushExp(w, 1'b0, 1'b1);
            else begin
               pushExp(w, 1'b0, 1'b0);
               pushExp(addiWord(d, d, lo), 1'b0, 1'b1);
            end
         end
         return;
      end
      ok = 1'b1;
      case (op)
         7'h03, 7'h13: begin
            ok = (v >= -2048 && v <= 2047);
            w  = ((u & 'hFFF) << 20) + (s1 << 15) + (f << 12) + (d << 7) + o;
         end
         7'h23: begin
            ok = (v >= -2048 && v <= 2047);
            w  = (((u >> 5) & 'h7F) << 25) + (s2 << 20) + (s1 << 15) + (f << 12)
                 + ((u & 'h1F) << 7) + o;
         end
         7'h63: begin
            ok = (v % 2 == 0) && v >= -4096 && v <= 4094;
            w  = (((u >> 12) & 1) << 31) + (((u >> 5) & 'h3F) << 25) + (s2 << 20) + (s1 << 15)
                 + (f << 12) + (((u >> 1) & 'hF) << 8) + (((u >> 11) & 1) << 7) + o;
         end
         7'h6F: begin
            ok = (v % 2 == 0) && v >= -(longint'(1) << 20) && v <= (longint'(1) << 20) - 2;
            w  = (((u >> 20) & 1) << 31) + (((u >> 1) & 'h3FF) << 21) + (((u >> 11) & 1) << 20)
                 + (((u >> 12) & 'hFF) << 12) + (d << 7) + o;
         end
         7'h37: begin
            ok = (u % 4096 == 0);
            w  = (u & 'hFFFFF000) + (d << 7) + o;
         end
         default: begin
            pushExp(longint'(NOP_INSTR), 1'b1, 1'b1);
            return;
         end
      endcase
      pushExp(w, STRICT && !ok, 1'b1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic setReq(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                         input logic li);
      in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_imm = imm; in_li = li;
   endtask

   // Called just after a falling edge; returns on the falling edge after the accepting edge.
   task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                                input logic li);
      int waited = 0;
      setReq(op, rd, rs1, rs2, f3, imm, li);
      #1;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic expectWord(input string tag, input logic [31:0] ins, input logic e, input logic l);
      checkOutput({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, ".instr"}, out_instr, ins);
      checkOutput({tag, ".err"}, {31'd0, out_err}, {31'd0, e});
      checkOutput({tag, ".last"}, {31'd0, out_last}, {31'd0, l});
      @(negedge clk);
   endtask

   task automatic drainModel(input string tag);
      while (exp_instr_q.size() > 0)
         expectWord(tag, exp_instr_q.pop_front(), exp_err_q.pop_front(), exp_last_q.pop_front());
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [6:0]  ops [0:6];
      logic [31:0] a_instr;
      logic [31:0] imm;
      int unsigned r;
      ops = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h33};

      repeat (2) @(negedge clk);
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_instr", out_instr, 32'd0);
      checkOutput("rst_err", {31'd0, out_err}, 32'd0);
      checkOutput("rst_last", {31'd0, out_last}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0);
      expectWord("t1_addi", 32'h00500093, 1'b0, 1'b1);

      applyStimulus(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4, 1'b0);
      expectWord("t2_beq", 32'hFE208EE3, 1'b0, 1'b1);
      applyStimulus(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b0);
      checkOutput("t2_odd_err", {31'd0, out_err}, 32'd1);
      @(negedge clk);

`ifdef LI_EXPAND_EN
      applyStimulus(7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF, 1'b1);
      checkOutput("t3_gap_ready", {31'd0, in_ready}, 32'd0);
      expectWord("t3_lui", 32'h123462B7, 1'b0, 1'b0);
      expectWord("t3_addi", 32'hFFF28293, 1'b0, 1'b1);
      applyStimulus(7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h000007FF, 1'b1);
      expectWord("t4_small", 32'h7FF00293, 1'b0, 1'b1);
      applyStimulus(7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 1'b1);
      expectWord("t4_luionly", 32'h123452B7, 1'b0, 1'b1);
      checkOutput("t4_idle", {31'd0, out_valid}, 32'd0);
`else
      applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1);
      expectWord("t3_li_ignored", 32'h00500093, 1'b0, 1'b1);
`endif

      out_ready = 1'b0;
      modelRequest(7'b0010011, 5'd2, 5'd3, 5'd0, 3'd4, 32'd100, 1'b0);
      a_instr = exp_instr_q.pop_front();
      void'(exp_err_q.pop_front());
      void'(exp_last_q.pop_front());
      applyStimulus(7'b0010011, 5'd2, 5'd3, 5'd0, 3'd4, 32'd100, 1'b0);
      modelRequest(7'b0100011, 5'd0, 5'd7, 5'd9, 3'd2, -32'sd16, 1'b0);
      setReq(7'b0100011, 5'd0, 5'd7, 5'd9, 3'd2, -32'sd16, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("t5_stable", out_instr, a_instr);
         checkOutput("t5_blocked", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("t5_release", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      drainModel("t5_next");

      applyStimulus(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 32'h00000123, 1'b0);
      expectWord("t6_badop", NOP_INSTR, 1'b1, 1'b1);

      out_ready = 1'b0;
`ifdef LI_EXPAND_EN
      applyStimulus(7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF, 1'b1);
`else
      applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0);
`endif
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("t6_rst_instr", out_instr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t6_no_pending", {31'd0, out_valid}, 32'd0);
      end

      $display("[TB] starting randomized requests");
      for (int n = 0; n < 150; n++) begin
         logic [6:0] op;
         logic [4:0] rd, rs1, rs2;
         logic [2:0] f3;
         logic       li;
         op  = ops[$urandom_range(0, 6)];
         rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
         f3  = 3'($urandom); li = 1'($urandom_range(0, 2) == 0);
         r   = $urandom;
         case ($urandom_range(0, 4))
            0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: imm = r;
            2: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'h1;
            3: imm = {{11{r[20]}}, r[20:1], 1'b0};
            default: imm = r & 32'hFFFFF000;
         endcase
         if ($urandom_range(0, 5) == 0) imm = imm ^ 32'h1;
         modelRequest(op, rd, rs1, rs2, f3, imm, li);
         applyStimulus(op, rd, rs1, rs2, f3, imm, li);
         drainModel("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
